// File: rtl/blitz_scoreboard_if.sv
// Handshake and display bundle between the binary-blitz round timer/target stage,
// the scoreboard and the board I/O.
interface blitz_scoreboard_if;
    logic       start;
    logic       round_end;
    logic [3:0] target;
    logic [3:0] answer;
    logic       round_enable;
    logic       result_valid;
    logic       result_correct;
    logic [7:0] score_tens_seg;
    logic [7:0] score_ones_seg;
    logic [3:0] lives_led;
    logic       game_over;
    logic       game_won;

    modport master (
        output start, round_end, target, answer,
        input  round_enable, result_valid, result_correct,
        input  score_tens_seg, score_ones_seg, lives_led, game_over, game_won
    );

    modport slave (
        input  start, round_end, target, answer,
        output round_enable, result_valid, result_correct,
        output score_tens_seg, score_ones_seg, lives_led, game_over, game_won
    );
endinterface

// File: rtl/blitz_scoreboard.sv
// Binary-blitz scoreboard: judges each round, keeps BCD score, streak and lives,
// sequences IDLE/PLAY/SHOW/OVER and drives the score digits and lives bar.
module blitz_scoreboard #(
    parameter int unsigned MAX_LIVES    = 3,
    parameter int unsigned SHOW_CYCLES  = 5000000,
    parameter int unsigned TARGET_SCORE = 20,
    parameter int unsigned STREAK_BONUS = 3
) (
    input logic               clk,
    input logic               rst,
    blitz_scoreboard_if.slave bus
);

    localparam int unsigned CNT_W   = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam int unsigned LIVES_W = 3;

    typedef enum logic [1:0] {IDLE, PLAY, SHOW, OVER} state_t;

    state_t             state_q, state_d;
    logic [3:0]         tens_q, tens_d, ones_q, ones_d;
    logic [3:0]         streak_q, streak_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               correct_q, correct_d;
    logic               won_q, won_d;
    logic               valid_d;
    logic [4:0]         sum;
    logic [6:0]         score_bin;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 8'hC0;
            4'd1:    return 8'hF9;
            4'd2:    return 8'hA4;
            4'd3:    return 8'hB0;
            4'd4:    return 8'h99;
            4'd5:    return 8'h92;
            4'd6:    return 8'h82;
            4'd7:    return 8'hF8;
            4'd8:    return 8'h80;
            4'd9:    return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [3:0] therm(input logic [LIVES_W-1:0] n);
        logic [7:0] t;
        t = (8'd1 << n) - 8'd1;
        return t[3:0];
    endfunction

    assign score_bin          = 7'(tens_q) * 7'd10 + 7'(ones_q);
    assign bus.result_correct = correct_q;
    assign bus.game_won       = won_q;

    // Next-state, scoring and round-judgement logic
    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        streak_d  = streak_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        correct_d = correct_q;
        won_d     = won_q;
        valid_d   = 1'b0;
        sum       = 5'd0;
        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d  = PLAY;
                    tens_d   = 4'd0;
                    ones_d   = 4'd0;
                    lives_d  = LIVES_W'(MAX_LIVES);
                    streak_d = 4'd0;
                    won_d    = 1'b0;
                    cnt_d    = '0;
                end
            end
            PLAY: begin
                if (bus.round_end) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    if (bus.answer == bus.target) begin
                        correct_d = 1'b1;
                        sum = 5'(ones_q) + ((32'(streak_q) >= STREAK_BONUS) ? 5'd2 : 5'd1);
                        if (sum >= 5'd10) begin
                            // carry out of the tens digit saturates the score at 99
                            if (tens_q == 4'd9) begin
                                ones_d = 4'd9;
                            end else begin
                                tens_d = tens_q + 4'd1;
                                ones_d = 4'(sum - 5'd10);
                            end
                        end else begin
                            ones_d = sum[3:0];
                        end
                        streak_d = (streak_q == 4'd15) ? 4'd15 : streak_q + 4'd1;
                    end else begin
                        correct_d = 1'b0;
                        lives_d   = (lives_q == '0) ? '0 : lives_q - LIVES_W'(1);
                        streak_d  = 4'd0;
                    end
                end
            end
            SHOW: begin
                if (cnt_q == CNT_W'(SHOW_CYCLES - 1)) begin
                    if (lives_q == '0) begin
                        state_d = OVER;
                        won_d   = 1'b0;
                    end else if (score_bin >= 7'(TARGET_SCORE)) begin
                        state_d = OVER;
                        won_d   = 1'b1;
                    end else begin
                        state_d = PLAY;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; display is decoded from next-state score
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            tens_q             <= 4'd0;
            ones_q             <= 4'd0;
            streak_q           <= 4'd0;
            lives_q            <= LIVES_W'(MAX_LIVES);
            cnt_q              <= '0;
            correct_q          <= 1'b0;
            won_q              <= 1'b0;
            bus.round_enable   <= 1'b0;
            bus.result_valid   <= 1'b0;
            bus.game_over      <= 1'b0;
            bus.score_tens_seg <= 8'hC0;
            bus.score_ones_seg <= 8'hC0;
            bus.lives_led      <= therm(LIVES_W'(MAX_LIVES));
        end else begin
            state_q            <= state_d;
            tens_q             <= tens_d;
            ones_q             <= ones_d;
            streak_q           <= streak_d;
            lives_q            <= lives_d;
            cnt_q              <= cnt_d;
            correct_q          <= correct_d;
            won_q              <= won_d;
            bus.round_enable   <= (state_d == PLAY);
            bus.result_valid   <= valid_d;
            bus.game_over      <= (state_d == OVER);
            bus.score_tens_seg <= seg7(tens_d);
            bus.score_ones_seg <= seg7(ones_d);
            bus.lives_led      <= therm(lives_d);
        end
    end

endmodule

// File: tb/tb_blitz_scoreboard.sv
// Randomized self-checking bench for blitz_scoreboard: two instances (short game and
// long carry/saturation game) checked against an integer game model.
module tb_blitz_scoreboard;

    localparam int SHOW0 = 4, LIVES0 = 3, TGT0 = 5;
    localparam int SHOW1 = 2, LIVES1 = 4, TGT1 = 99;
    localparam int BONUS = 3;

    typedef struct packed {
        logic       round_enable;
        logic       result_valid;
        logic       result_correct;
        logic [7:0] tens;
        logic [7:0] ones;
        logic [3:0] lives;
        logic       over;
        logic       won;
    } obs_t;

    typedef struct {
        int score;
        int lives;
        int streak;
        int over;
        int won;
        int max_lives;
        int target;
        int show;
    } model_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   total = 0;
    int   bad   = 0;
    logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    always #5 clk = ~clk;

    blitz_scoreboard_if bus0 ();
    blitz_scoreboard_if bus1 ();

    blitz_scoreboard #(.MAX_LIVES(LIVES0), .SHOW_CYCLES(SHOW0), .TARGET_SCORE(TGT0),
                       .STREAK_BONUS(BONUS))
        u_dut0 (.clk(clk), .rst(rst0), .bus(bus0));

    blitz_scoreboard #(.MAX_LIVES(LIVES1), .SHOW_CYCLES(SHOW1), .TARGET_SCORE(TGT1),
                       .STREAK_BONUS(BONUS))
        u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obs_t observe(input int id);
        obs_t o;
        if (id == 0) begin
            o = '{bus0.round_enable, bus0.result_valid, bus0.result_correct, bus0.score_tens_seg,
                  bus0.score_ones_seg, bus0.lives_led, bus0.game_over, bus0.game_won};
        end else begin
            o = '{bus1.round_enable, bus1.result_valid, bus1.result_correct, bus1.score_tens_seg,
                  bus1.score_ones_seg, bus1.lives_led, bus1.game_over, bus1.game_won};
        end
        return o;
    endfunction

    task automatic drive(input int id, input logic s, input logic re,
                         input logic [3:0] t, input logic [3:0] a);
        if (id == 0) begin
            bus0.start = s; bus0.round_end = re; bus0.target = t; bus0.answer = a;
        end else begin
            bus1.start = s; bus1.round_end = re; bus1.target = t; bus1.answer = a;
        end
    endtask

    task automatic check_disp(input int id, input model_t m, input string tag);
        obs_t o;
        o = observe(id);
        check($sformatf("u%0d %s tens", id, tag), int'(o.tens), int'(seg_tab[m.score / 10]));
        check($sformatf("u%0d %s ones", id, tag), int'(o.ones), int'(seg_tab[m.score % 10]));
        check($sformatf("u%0d %s lives", id, tag), int'(o.lives), (1 << m.lives) - 1);
    endtask

    task automatic model_new(inout model_t m);
        m.score = 0; m.lives = m.max_lives; m.streak = 0; m.over = 0; m.won = 0;
    endtask

    task automatic do_start(input int id, inout model_t m);
        obs_t o;
        drive(id, 1'b1, 1'b0, 4'd0, 4'd0);
        step();
        drive(id, 1'b0, 1'b0, 4'd0, 4'd0);
        model_new(m);
        o = observe(id);
        check($sformatf("u%0d start re", id), int'(o.round_enable), 1);
        check($sformatf("u%0d start over", id), int'(o.over), 0);
        check($sformatf("u%0d start won", id), int'(o.won), 0);
        check_disp(id, m, "start");
    endtask

    task automatic play_round(input int id, inout model_t m, input bit correct);
        obs_t       o;
        logic [3:0] t, a;
        int         n;
        o = observe(id);
        check($sformatf("u%0d re before round", id), int'(o.round_enable), 1);
        if ($urandom_range(0, 1) == 1) begin
            drive(id, 1'b1, 1'b0, 4'd0, 4'd0);
            step();
            drive(id, 1'b0, 1'b0, 4'd0, 4'd0);
            o = observe(id);
            check($sformatf("u%0d start in play re", id), int'(o.round_enable), 1);
            check($sformatf("u%0d start in play rv", id), int'(o.result_valid), 0);
            check_disp(id, m, "start in play");
        end
        t = 4'($urandom_range(0, 15));
        a = correct ? t : (t ^ 4'($urandom_range(1, 15)));
        drive(id, 1'($urandom_range(0, 1)), 1'b1, t, a);
        step();
        drive(id, 1'b0, 1'b0, t, a);
        if (correct) begin
            m.score  = (m.score + ((m.streak >= BONUS) ? 2 : 1) > 99) ? 99
                     : m.score + ((m.streak >= BONUS) ? 2 : 1);
            m.streak = (m.streak >= 15) ? 15 : m.streak + 1;
        end else begin
            m.lives  = (m.lives > 0) ? m.lives - 1 : 0;
            m.streak = 0;
        end
        o = observe(id);
        check($sformatf("u%0d result_valid", id), int'(o.result_valid), 1);
        check($sformatf("u%0d result_correct", id), int'(o.result_correct), int'(correct));
        check($sformatf("u%0d re in show", id), int'(o.round_enable), 0);
        check_disp(id, m, "judged");
        n = 1;
        for (int i = 0; i < 64; i++) begin
            drive(id, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), t, a);
            step();
            o = observe(id);
            if (i == 0) check($sformatf("u%0d rv one cycle", id), int'(o.result_valid), 0);
            if (o.round_enable || o.over) break;
            n++;
        end
        drive(id, 1'b0, 1'b0, 4'd0, 4'd0);
        check($sformatf("u%0d show length", id), n, m.show);
        if (m.lives == 0) begin
            m.over = 1; m.won = 0;
        end else if (m.score >= m.target) begin
            m.over = 1; m.won = 1;
        end
        check($sformatf("u%0d game_over", id), int'(o.over), m.over);
        check($sformatf("u%0d game_won", id), int'(o.won), m.won);
        check($sformatf("u%0d re after show", id), int'(o.round_enable), 1 - m.over);
        check_disp(id, m, "after show");
    endtask

    initial begin
        model_t     m0, m1;
        obs_t       o;
        logic [3:0] t;
        int         r;
        m0.max_lives = LIVES0; m0.target = TGT0; m0.show = SHOW0;
        m1.max_lives = LIVES1; m1.target = TGT1; m1.show = SHOW1;
        model_new(m0);
        model_new(m1);

        // reset, then IDLE ignores round_end
        rst0 = 1'b1; rst1 = 1'b1;
        drive(0, 1'b0, 1'b1, 4'd3, 4'd3);
        drive(1, 1'b0, 1'b0, 4'd0, 4'd0);
        step(); step();
        rst0 = 1'b0; rst1 = 1'b0;
        step(); step();
        drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
        for (int id = 0; id < 2; id++) begin
            o = observe(id);
            check($sformatf("u%0d idle re", id), int'(o.round_enable), 0);
            check($sformatf("u%0d idle rv", id), int'(o.result_valid), 0);
            check($sformatf("u%0d idle rc", id), int'(o.result_correct), 0);
            check($sformatf("u%0d idle over", id), int'(o.over), 0);
            check($sformatf("u%0d idle won", id), int'(o.won), 0);
            check_disp(id, (id == 0) ? m0 : m1, "idle");
        end

        // one correct then three wrong: lose
        do_start(0, m0);
        play_round(0, m0, 1'b1);
        for (int k = 0; k < 3; k++) play_round(0, m0, 1'b0);

        // OVER ignores round_end and freezes display
        drive(0, 1'b0, 1'b1, 4'd1, 4'd1);
        step();
        drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        o = observe(0);
        check("u0 over ignores round_end rv", int'(o.result_valid), 0);
        check("u0 over held", int'(o.over), 1);
        check("u0 over re", int'(o.round_enable), 0);
        check_disp(0, m0, "over frozen");

        // four correct: streak bonus on the fourth, win at 5
        do_start(0, m0);
        for (int k = 0; k < 4; k++) play_round(0, m0, 1'b1);

        // random game
        do_start(0, m0);
        r = 0;
        while (m0.over == 0 && r < 40) begin
            play_round(0, m0, $urandom_range(0, 2) != 0);
            r++;
        end

        // reset during SHOW with score 3
        do_start(0, m0);
        play_round(0, m0, 1'b1);
        play_round(0, m0, 1'b1);
        t = 4'($urandom_range(0, 15));
        drive(0, 1'b0, 1'b1, t, t);
        step();
        drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
        m0.score = 3;
        check_disp(0, m0, "score3");
        step(); step();
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        model_new(m0);
        o = observe(0);
        check("u0 midshow rst re", int'(o.round_enable), 0);
        check("u0 midshow rst rv", int'(o.result_valid), 0);
        check("u0 midshow rst rc", int'(o.result_correct), 0);
        check("u0 midshow rst over", int'(o.over), 0);
        check_disp(0, m0, "midshow rst");
        drive(0, 1'b0, 1'b1, 4'd2, 4'd2);
        step();
        drive(0, 1'b0, 1'b0, 4'd0, 4'd0);
        step();
        o = observe(0);
        check("u0 idle after rst rv", int'(o.result_valid), 0);
        check("u0 idle after rst re", int'(o.round_enable), 0);

        // long game toward 99: BCD carry and saturation
        do_start(1, m1);
        r = 0;
        while (m1.over == 0 && r < 200) begin
            play_round(1, m1, !($urandom_range(0, 5) == 0 && m1.lives > 1));
            r++;
        end
        check("u1 long game ended", m1.over, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/blitz_scoreboard.md
Name: blitz_scoreboard

Overview:
- Downstream consumer of the round timer / target-generator stage in the binary-blitz game.
- At each round end it compares the player's switch value against the target, then updates a BCD score, a correct-answer streak and a lives count.
- Drives two active-low 7-segment score digits and a lives LED bar.
- Sequences play through IDLE/PLAY/SHOW/OVER and gates the upstream round timer via round_enable.

Parameters:
- MAX_LIVES, 3, starting lives; legal range 1..4.
- SHOW_CYCLES, 5000000, clk cycles the result is held before the next round (0.5 s at 10 MHz); minimum 2.
- TARGET_SCORE, 20, decimal score that wins the game; legal range 1..99.
- STREAK_BONUS, 3, streak length (before the current round) at which a correct answer scores +2 instead of +1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse from the debounced push button.
- round_end  in  1  single-cycle pulse from the round timer when its countdown reaches 0.
- target  in  4  current target value from the target generator.
- answer  in  4  player switch value.
- round_enable  out  1  high while a round may run; upstream timer holds/reloads while low.
- result_valid  out  1  single-cycle pulse when a round has been judged.
- result_correct  out  1  verdict of the last judged round; held until the next judgement.
- score_tens_seg  out  8  active-low {dp,g,f,e,d,c,b,a}, tens BCD digit.
- score_ones_seg  out  8  same encoding, ones BCD digit.
- lives_led  out  4  thermometer of lives remaining (2 lives = 4'b0011).
- game_over  out  1  high in OVER.
- game_won  out  1  high in OVER when the target score was reached; 0 otherwise.

Behaviour:
- Reset (clk edge with rst=1, any state, including mid-round):
  - state IDLE; score 00; streak 0; lives MAX_LIVES; show counter 0.
  - round_enable 0, result_valid 0, result_correct 0, game_over 0, game_won 0.
  - Both digits show "0" (8'b11000000); lives_led is the thermometer of MAX_LIVES.
- All outputs are registered; the segment encode is a registered decode of the BCD score. dp is always 1 (off).
- Digit codes 0-9: C0, F9, A4, B0, 99, 92, 82, F8, 80, 90 (hex).
- IDLE:
  - round_enable 0; round_end ignored.
  - start -> PLAY. On that edge: score=00, lives=MAX_LIVES, streak=0, game_won=0.
- PLAY:
  - round_enable 1; start ignored.
  - round_end: sample answer and target on that same edge; correct = (answer==target).
  - Next cycle: result_valid=1 for exactly one cycle, result_correct=correct, score/lives/streak already updated, state SHOW, show counter=0.
- Correct answer:
  - Points = 2 if the streak before this round is >= STREAK_BONUS, else 1.
  - Score is a 2-digit BCD add: ones wrap 9->0 with carry into tens.
  - Score saturates at 99 (98+2=99, 99+1=99).
  - Streak increments, saturating at 15.
- Wrong answer: lives decrements (never below 0); streak=0; score unchanged.
- SHOW:
  - round_enable 0; round_end and start ignored; counter increments each cycle.
  - When counter == SHOW_CYCLES-1, on the next edge:
    - lives==0 -> OVER, game_won=0.
    - else if score >= TARGET_SCORE (tens*10+ones) -> OVER, game_won=1.
    - else -> PLAY.
  - lives==0 takes priority over a winning score.
- OVER:
  - game_over 1; round_enable 0; round_end ignored; score display frozen.
  - start -> PLAY with the same initialisation as IDLE->PLAY; game_over and game_won drop on that edge.
- Simultaneous start and round_end in PLAY: round_end is judged and start is dropped.
- rst has priority over every other input.

Test Plan (SHOW_CYCLES=4, MAX_LIVES=3, TARGET_SCORE=5, STREAK_BONUS=3):
- Reset then idle: rst 2 cycles, no start, round_end pulsed -> state stays IDLE, round_enable=0, segs C0/C0, lives_led=0111, no result_valid.
- Single correct round: start; target=9, answer=9, round_end -> next cycle result_valid=1 (one cycle), result_correct=1, ones seg F9; round_enable low for exactly 4 cycles then back to 1.
- Wrong rounds to game over: 3 rounds with answer!=target -> lives_led 0011, 0001, 0000; after the third SHOW: game_over=1, game_won=0, round_enable=0.
- Streak bonus and win: 4 consecutive correct rounds -> score 1,2,3,5 (fourth round +2) -> after SHOW: game_won=1, game_over=1, segs C0/92.
- Restart from OVER: start pulse -> game_over=0, score 00, lives_led 0111, round_enable=1 next cycle; start pulsed in PLAY and SHOW has no effect.
- Reset mid-SHOW after score 3: rst during SHOW counter=2 -> IDLE next edge, score 00, result_correct=0, no further result_valid.
